// File: rtl/layer2_classifier.sv
// Output layer of the MNIST network: serial MAC over the ten layer-1 activations,
// bias add, then serial argmax producing the class index, a one-hot LED vector and the score.
module layer2_classifier #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FRAC_BITS = 16,
  parameter int unsigned N_IN      = 10,
  parameter int unsigned N_OUT     = 10,
  parameter int unsigned ACC_W     = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_IN*DATA_W-1:0]  relu_in,
  output logic [3:0]              weight_addr,
  input  logic [N_OUT*DATA_W-1:0] w_value,
  output logic [3:0]              bias_addr,
  input  logic [DATA_W-1:0]       bias_value,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              class_idx,
  output logic [N_OUT-1:0]        class_onehot,
  output logic [DATA_W-1:0]       score_max
);

  localparam int unsigned CntMax = (N_IN > N_OUT) ? N_IN : N_OUT;
  localparam int unsigned CNT_W  = $clog2(CntMax + 1);

  localparam logic [CNT_W-1:0] MacLast    = CNT_W'(N_IN);
  localparam logic [CNT_W-1:0] BiasLast   = CNT_W'(N_OUT);
  localparam logic [CNT_W-1:0] ArgmaxLast = CNT_W'(N_OUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StMac,
    StBias,
    StArgmax,
    StDone
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]         relu_q [N_IN];
  logic signed [ACC_W-1:0]   acc_q [N_OUT];
  logic signed [DATA_W-1:0]  max_val_q;
  logic [3:0]                max_idx_q;
  logic                      busy_q;
  logic                      done_q;
  logic [3:0]                class_idx_q;
  logic [N_OUT-1:0]          class_onehot_q;
  logic [DATA_W-1:0]         score_max_q;

  logic signed [DATA_W-1:0]   relu_sel;
  logic signed [2*DATA_W-1:0] prod [N_OUT];
  logic signed [ACC_W-1:0]    mac_inc [N_OUT];
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    acc_sel;
  logic [ACC_W-DATA_W:0]      acc_hi;
  logic signed [DATA_W-1:0]   score_k;

  // FSM next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StMac;
          cnt_d   = '0;
        end
      end
      StMac: begin
        if (cnt_q == MacLast) begin
          state_d = StBias;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBias: begin
        if (cnt_q == BiasLast) begin
          state_d = StArgmax;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StArgmax: begin
        if (cnt_q == ArgmaxLast) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ROM addresses are zero outside their own phase
  always_comb begin
    weight_addr = '0;
    bias_addr   = '0;
    if (state_q == StMac && cnt_q < MacLast) begin
      weight_addr = 4'(cnt_q);
    end
    if (state_q == StBias && cnt_q < BiasLast) begin
      bias_addr = 4'(cnt_q);
    end
  end

  // Activation paired with the weight word returned for address cnt-1
  always_comb begin
    relu_sel = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (cnt_q == CNT_W'(i + 1)) begin
        relu_sel = relu_q[i];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < int'(N_OUT); j++) begin
      prod[j]    = $signed(relu_sel) * $signed(w_value[j*DATA_W +: DATA_W]);
      mac_inc[j] = ACC_W'(prod[j] >>> FRAC_BITS);
    end
  end

  assign bias_ext = {{(ACC_W - DATA_W){bias_value[DATA_W-1]}}, bias_value};

  // Saturate the accumulator under inspection to the signed DATA_W range
  always_comb begin
    acc_sel = '0;
    for (int k = 0; k < int'(N_OUT); k++) begin
      if (cnt_q == CNT_W'(k)) begin
        acc_sel = acc_q[k];
      end
    end
    acc_hi = acc_sel[ACC_W-1:DATA_W-1];
    if ((&acc_hi) || !(|acc_hi)) begin
      score_k = acc_sel[DATA_W-1:0];
    end else if (acc_sel[ACC_W-1]) begin
      score_k = {1'b1, {(DATA_W - 1){1'b0}}};
    end else begin
      score_k = {1'b0, {(DATA_W - 1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(N_IN); i++) begin
        relu_q[i] <= '0;
      end
      for (int j = 0; j < int'(N_OUT); j++) begin
        acc_q[j] <= '0;
      end
      max_val_q      <= '0;
      max_idx_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      class_idx_q    <= '0;
      class_onehot_q <= '0;
      score_max_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            for (int i = 0; i < int'(N_IN); i++) begin
              relu_q[i] <= relu_in[i*DATA_W +: DATA_W];
            end
            for (int j = 0; j < int'(N_OUT); j++) begin
              acc_q[j] <= '0;
            end
            busy_q <= 1'b1;
          end
        end
        StMac: begin
          if (cnt_q != '0) begin
            for (int j = 0; j < int'(N_OUT); j++) begin
              acc_q[j] <= acc_q[j] + mac_inc[j];
            end
          end
        end
        StBias: begin
          for (int j = 0; j < int'(N_OUT); j++) begin
            if (cnt_q == CNT_W'(j + 1)) begin
              acc_q[j] <= acc_q[j] + bias_ext;
            end
          end
        end
        StArgmax: begin
          // Strict compare keeps the lowest index on ties
          if (cnt_q == '0 || score_k > max_val_q) begin
            max_val_q <= score_k;
            max_idx_q <= 4'(cnt_q);
          end
        end
        StDone: begin
          class_idx_q    <= max_idx_q;
          class_onehot_q <= {{(N_OUT - 1){1'b0}}, 1'b1} << max_idx_q;
          score_max_q    <= max_val_q;
          done_q         <= 1'b1;
          busy_q         <= 1'b0;
        end
        default: begin
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign class_idx    = class_idx_q;
  assign class_onehot = class_onehot_q;
  assign score_max    = score_max_q;

endmodule
